// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and default bit timing.
package uart_pkg;

   // Data bits per frame (8N1).
   localparam int unsigned UART_DATA_BITS = 8;

   // 100 MHz / 115200 baud; shared with the transmitter.
   localparam int unsigned UART_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through output.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;

   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
   always_comb begin
      o_empty = (wr_ptr_q == rd_ptr_q);
      o_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
      do_pop  = i_pop && !o_empty;
      do_push = i_push && (!o_full || do_pop);
      o_data  = mem_q[rd_ptr_q[AddrW-1:0]];
   end

   // Pointer registers; they wrap naturally through the extra MSB.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   // Storage is cleared on reset so the head output reads zero while empty.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= i_data;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, decodes frames by mid-bit sampling and queues
// completed bytes in a FIFO drained through a valid/ready handshake.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int unsigned         CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0]     CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]     CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]          IdxLast = 3'(UART_DATA_BITS - 1);

   logic rx_meta_q, rx_s_q, rx_s;

   uart_rx_state_t state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;

   logic push, pop, fifo_full, fifo_empty;

   // Two-flop synchroniser; flops reset to the idle line level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign rx_s = rx_s_q;

   // Receiver state, timing counters, shift register and one-cycle flag pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Frame decoder: next state, bit sampling, push request and error detection.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            // Re-check the line at mid start bit; a short low pulse is ignored silently.
            if (cnt_q == CntMid) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         DATA: begin
            if (cnt_q == CntLast) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IdxLast) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         STOP: begin
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RECOVER;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         RECOVER: begin
            // Hold off until the line returns high so a break is not read as 0x00 frames.
            if (rx_s) state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and overrun: a push into a full FIFO is lost unless a pop frees a slot.
   always_comb begin
      o_valid   = !fifo_empty;
      pop       = o_valid && i_ready;
      overrun_d = push && fifo_full && !pop;
   end

   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
   assign o_busy      = (state_q != IDLE);

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (shift_q),
      .i_pop   (pop),
      .o_data  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic, checked
// against a frame-level model (bounded queue, error/overrun counters).
module tb_uart_rx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Frame-level reference model.
   logic [7:0] mdl_fifo[$];
   logic [7:0] mdl_out[$];
   bit         mdl_ready = 1'b0;
   int         exp_ferr = 0;
   int         exp_ovr  = 0;

   // Observations.
   logic [7:0] got_q[$];
   int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, ferr_long = 0, ovr_long = 0;
   int valid_cycles = 0;
   logic ferr_prev = 1'b0, ovr_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx        (rx),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_frame_err (frame_err),
      .o_overrun   (overrun),
      .o_busy      (busy)
   );

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) got_q.push_back(data);
         if (valid) valid_cycles++;
         if (frame_err) ferr_cnt++;
         if (overrun) ovr_cnt++;
         if (frame_err && overrun) both_cnt++;
         if (frame_err && ferr_prev) ferr_long++;
         if (overrun && ovr_prev) ovr_long++;
      end
      ferr_prev = frame_err;
      ovr_prev  = overrun;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic mdl_drain();
      while (mdl_fifo.size() > 0) mdl_out.push_back(mdl_fifo.pop_front());
   endtask

   task automatic set_ready(input bit r);
      ready     = r;
      mdl_ready = r;
      if (r) mdl_drain();
   endtask

   // One completed frame as seen by the model.
   task automatic mdl_frame(input logic [7:0] b, input bit good);
      if (!good) exp_ferr++;
      else if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(b);
      else exp_ovr++;
      if (mdl_ready) mdl_drain();
   endtask

   // Drives start, 8 data bits LSB first and the stop bit; rx is left at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop_bit;
      idle(CPB);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_count"}, got_q.size(), mdl_out.size());
      for (int i = 0; i < mdl_out.size() && i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got_q[i], mdl_out[i]);
      got_q.delete();
      mdl_out.delete();
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_ferr"}, ferr_cnt, exp_ferr);
      check({tag, "_ovr"}, ovr_cnt, exp_ovr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int v0;
      logic [7:0] b;
      bit good;

      // Reset state.
      idle(3);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      rst = 1'b0;
      idle(4);
      check("post_rst_busy", busy, 0);

      // 1: single good frame, immediate consumer.
      set_ready(1);
      v0 = valid_cycles;
      send_frame(8'hA5, 1'b1);
      mdl_frame(8'hA5, 1'b1);
      idle(8);
      compare_stream("t1");
      check("t1_valid_cycles", valid_cycles - v0, 1);
      check_flags("t1");
      check("t1_busy", busy, 0);

      // 2: one-cycle glitch is rejected at mid start bit.
      rx = 1'b0;
      tick();
      rx = 1'b1;
      idle(10);
      compare_stream("t2");
      check_flags("t2");
      check("t2_busy", busy, 0);
      check("t2_valid", valid, 0);

      // 3: framing error followed by a held break, then a good frame.
      send_frame(8'h3C, 1'b0);
      mdl_frame(8'h3C, 1'b0);
      idle(3 * CPB);
      rx = 1'b1;
      idle(8);
      check("t3_busy_recovered", busy, 0);
      send_frame(8'h81, 1'b1);
      mdl_frame(8'h81, 1'b1);
      idle(8);
      compare_stream("t3");
      check_flags("t3");

      // 4: consumer stalled, five frames -> one overrun, four bytes drain.
      set_ready(0);
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1);
         mdl_frame(8'(i), 1'b1);
      end
      idle(8);
      check_flags("t4");
      set_ready(1);
      idle(8);
      compare_stream("t4");
      check("t4_valid_empty", valid, 0);

      // 5: full FIFO, ready asserted exactly in the fifth byte's push cycle.
      set_ready(0);
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1);
         mdl_frame(8'(i), 1'b1);
      end
      send_frame(8'h05, 1'b1);
      set_ready(1);
      mdl_frame(8'h05, 1'b1);
      idle(10);
      compare_stream("t5");
      check_flags("t5");
      check("t5_valid_empty", valid, 0);

      // 6: reset mid-frame with two bytes queued.
      set_ready(0);
      send_frame(8'h11, 1'b1);
      mdl_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      mdl_frame(8'h22, 1'b1);
      rx = 1'b0;
      idle(CPB);
      b = 8'hF0;
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         idle(CPB);
      end
      check("t6_pre_busy", busy, 1);
      check("t6_pre_valid", valid, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", valid, 0);
      check("t6_rst_data", data, 0);
      check("t6_rst_busy", busy, 0);
      mdl_fifo.delete();
      rx = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(4);
      set_ready(1);
      send_frame(8'h5A, 1'b1);
      mdl_frame(8'h5A, 1'b1);
      idle(8);
      compare_stream("t6");
      check_flags("t6");

      // Randomized traffic with a live consumer and random gaps.
      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(b, good);
         mdl_frame(b, good);
         if (!good) begin
            idle(CPB * $urandom_range(0, 3));
            rx = 1'b1;
            idle(CPB);
         end
         idle($urandom_range(0, 5));
      end
      idle(8);
      compare_stream("rnd");
      check_flags("rnd");

      // Randomized stalled bursts that may overflow the FIFO.
      for (int k = 0; k < 3; k++) begin
         set_ready(0);
         for (int n = 0; n < $urandom_range(1, 6); n++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            mdl_frame(b, good);
            if (!good) begin
               rx = 1'b1;
               idle(CPB);
            end
         end
         idle(4);
         set_ready(1);
         idle(8);
         compare_stream($sformatf("burst%0d", k));
         check_flags($sformatf("burst%0d", k));
      end

      // Pulse shape invariants and final quiescence.
      check("both_flags", both_cnt, 0);
      check("ferr_width", ferr_long, 0);
      check("ovr_width", ovr_long, 0);
      check("end_valid", valid, 0);
      check("end_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
